// File: rtl/hx8352_bus_arbiter.sv
// HX8352 parallel write-bus arbiter: two valid/ready requesters share one
// 16-bit bus. Ownership is round-robin at burst boundaries, and the
// CS/RS/WR strobes are timed from the cycle-count parameters below.
//
// state  | meaning
// IDLE   | bus free, arbitrating between requesters
// SETUP  | CS low, RS/data driven, WR high
// STROBE | WR low
// HOLD   | WR high, data held; last cycle decides next beat / wait / gap
// WAIT   | burst open, owner has no beat yet; CS stays low
// GAP    | CS high between bursts
module hx8352_bus_arbiter #(
   parameter int T_SETUP  = 1,
   parameter int T_WR_LOW = 2,
   parameter int T_HOLD   = 1,
   parameter int T_CS_GAP = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req0_rs,
   input  logic [15:0] req0_data,
   input  logic        req0_last,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic        req1_rs,
   input  logic [15:0] req1_data,
   input  logic        req1_last,
   output logic        req1_ready,
   output logic        lcd_cs,
   output logic        lcd_rs,
   output logic        lcd_wr,
   output logic        lcd_rd,
   output logic [15:0] data_output,
   output logic [1:0]  grant,
   output logic        busy
);

   // A zero count would make a state vanish, so it is clamped to one cycle.
   localparam int TS_E = (T_SETUP  < 1) ? 1 : T_SETUP;
   localparam int TW_E = (T_WR_LOW < 1) ? 1 : T_WR_LOW;
   localparam int TH_E = (T_HOLD   < 1) ? 1 : T_HOLD;
   localparam int TG_E = (T_CS_GAP < 1) ? 1 : T_CS_GAP;

   localparam logic [3:0] LD_SETUP = 4'(TS_E - 1);
   localparam logic [3:0] LD_WR    = 4'(TW_E - 1);
   localparam logic [3:0] LD_HOLD  = 4'(TH_E - 1);
   localparam logic [3:0] LD_GAP   = 4'(TG_E - 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT, GAP} state_t;

   state_t     state;
   logic [3:0] phase;
   logic       owner;
   logic       last_l;
   logic       last_owner;
   logic       pick0;
   logic       pick1;
   logic       cont;
   logic       accept;

   assign lcd_rd = 1'b1;

   // Tie goes to the requester that did not own the previous burst.
   assign pick0 = req0_valid && (!req1_valid || last_owner);
   assign pick1 = req1_valid && (!req0_valid || !last_owner);
   assign cont  = (state == WAIT) || (state == HOLD && phase == 4'd0 && !last_l);

   // Combinational ready: arbitration in IDLE, owner-only inside a burst.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst) begin
         if (state == IDLE) begin
            req0_ready = pick0;
            req1_ready = pick1;
         end else if (cont) begin
            req0_ready = !owner && req0_valid;
            req1_ready = owner && req1_valid;
         end
      end
   end

   assign accept = req0_ready || req1_ready;

   // Sequencer state, phase down-counter, beat latch and registered bus pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         phase       <= 4'd0;
         owner       <= 1'b0;
         last_l      <= 1'b0;
         last_owner  <= 1'b1;
         lcd_cs      <= 1'b1;
         lcd_wr      <= 1'b1;
         lcd_rs      <= 1'b1;
         data_output <= 16'h0000;
         grant       <= 2'b00;
         busy        <= 1'b0;
      end else if (accept) begin
         owner       <= req1_ready;
         last_l      <= req1_ready ? req1_last : req0_last;
         lcd_rs      <= req1_ready ? req1_rs : req0_rs;
         data_output <= req1_ready ? req1_data : req0_data;
         grant       <= req1_ready ? 2'b10 : 2'b01;
         state       <= SETUP;
         phase       <= LD_SETUP;
         lcd_cs      <= 1'b0;
         lcd_wr      <= 1'b1;
         busy        <= 1'b1;
      end else begin
         case (state)
            IDLE, WAIT: ;
            SETUP: begin
               if (phase == 4'd0) begin
                  state  <= STROBE;
                  phase  <= LD_WR;
                  lcd_wr <= 1'b0;
               end else begin
                  phase <= phase - 4'd1;
               end
            end
            STROBE: begin
               if (phase == 4'd0) begin
                  state  <= HOLD;
                  phase  <= LD_HOLD;
                  lcd_wr <= 1'b1;
               end else begin
                  phase <= phase - 4'd1;
               end
            end
            HOLD: begin
               if (phase == 4'd0) begin
                  if (last_l) begin
                     state      <= GAP;
                     phase      <= LD_GAP;
                     lcd_cs     <= 1'b1;
                     grant      <= 2'b00;
                     last_owner <= owner;
                  end else begin
                     state <= WAIT;
                  end
               end else begin
                  phase <= phase - 4'd1;
               end
            end
            GAP: begin
               if (phase == 4'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  phase <= phase - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hx8352_bus_arbiter.sv
// Directed bench for hx8352_bus_arbiter: default-timing instance driven from
// per-requester beat queues, plus a second instance with non-default timing.
module tb_hx8352_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        req0_valid, req0_rs, req0_last, req0_ready;
   logic        req1_valid, req1_rs, req1_last, req1_ready;
   logic [15:0] req0_data, req1_data;
   logic        lcd_cs, lcd_rs, lcd_wr, lcd_rd, busy;
   logic [15:0] data_output;
   logic [1:0]  grant;

   logic        b_req0_valid, b_req0_rs, b_req0_last, b_req0_ready;
   logic        b_req1_ready;
   logic [15:0] b_req0_data;
   logic        b_lcd_cs, b_lcd_rs, b_lcd_wr, b_lcd_rd, b_busy;
   logic [15:0] b_data_output;
   logic [1:0]  b_grant;

   int checks = 0;
   int failures = 0;

   logic [17:0] q0[$];
   logic [17:0] q1[$];
   int          acc_log[$];
   bit          en0, en1;

   hx8352_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
      .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
      .req1_last(req1_last), .req1_ready(req1_ready),
      .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr), .lcd_rd(lcd_rd),
      .data_output(data_output), .grant(grant), .busy(busy)
   );

   hx8352_bus_arbiter #(.T_SETUP(2), .T_WR_LOW(3), .T_HOLD(0), .T_CS_GAP(1)) dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(b_req0_valid), .req0_rs(b_req0_rs), .req0_data(b_req0_data),
      .req0_last(b_req0_last), .req0_ready(b_req0_ready),
      .req1_valid(1'b0), .req1_rs(1'b0), .req1_data(16'h0000),
      .req1_last(1'b0), .req1_ready(b_req1_ready),
      .lcd_cs(b_lcd_cs), .lcd_rs(b_lcd_rs), .lcd_wr(b_lcd_wr), .lcd_rd(b_lcd_rd),
      .data_output(b_data_output), .grant(b_grant), .busy(b_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Requester model: present queued beats, pop on handshake, log acceptances.
   initial begin
      bit a0, a1;
      req0_valid = 0; req0_rs = 0; req0_data = 0; req0_last = 0;
      req1_valid = 0; req1_rs = 0; req1_data = 0; req1_last = 0;
      forever begin
         @(negedge clk);
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         chk("ready_excl", {31'b0, req0_ready && req1_ready}, 0);
         if (a0 || a1) acc_log.push_back(a1 ? 2 : 1);
         @(posedge clk);
         #1;
         if (a0 && q0.size() > 0) void'(q0.pop_front());
         if (a1 && q1.size() > 0) void'(q1.pop_front());
         req0_valid = en0 && (q0.size() > 0);
         req1_valid = en1 && (q1.size() > 0);
         if (q0.size() > 0) {req0_last, req0_rs, req0_data} = q0[0];
         if (q1.size() > 0) {req1_last, req1_rs, req1_data} = q1[0];
      end
   end

   task automatic wait_rdy(input int which, input string tag);
      bit seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         seen = (which == 1) ? req1_ready : req0_ready;
      end
      chk(tag, {31'b0, seen}, 1);
   endtask

   task automatic wait_idle(input string tag);
      bit done = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         done = !busy && q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid;
      end
      chk(tag, {31'b0, done}, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1; en0 = 0; en1 = 0;
      b_req0_valid = 0; b_req0_rs = 0; b_req0_data = 0; b_req0_last = 0;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_cs", lcd_cs, 1);
      chk("rst_wr", lcd_wr, 1);
      chk("rst_rd", lcd_rd, 1);
      chk("rst_rs", lcd_rs, 1);
      chk("rst_data", data_output, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      rst = 0;

      // single req0 beat, default timing
      q0.push_back({1'b1, 1'b0, 16'h0022});
      en0 = 1;
      wait_rdy(0, "t1_rdy0");
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         chk($sformatf("t1_cs_c%0d", i), lcd_cs, (i <= 4) ? 0 : 1);
         chk($sformatf("t1_wr_c%0d", i), lcd_wr, (i == 2 || i == 3) ? 0 : 1);
         chk($sformatf("t1_busy_c%0d", i), busy, (i <= 6) ? 1 : 0);
         chk($sformatf("t1_grant_c%0d", i), grant, (i <= 4) ? 1 : 0);
         if (i == 1) begin
            chk("t1_data", data_output, 16'h0022);
            chk("t1_rs", lcd_rs, 0);
         end
      end

      // both requesters from reset, three single-beat bursts each
      rst = 1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         q0.push_back({1'b1, 1'b1, 16'(16'h0100 + k)});
         q1.push_back({1'b1, 1'b1, 16'(16'h0200 + k)});
      end
      en0 = 1; en1 = 1;
      acc_log.delete();
      rst = 0;
      seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         seen = (acc_log.size() >= 6);
      end
      chk("t2_six_accepts", {31'b0, seen}, 1);
      for (int k = 0; k < 6; k++)
         chk($sformatf("t2_order_%0d", k), (k < acc_log.size()) ? acc_log[k] : 0, (k % 2 == 0) ? 1 : 2);
      wait_idle("t2_idle");

      // req1 four-beat burst while req0 waits
      en0 = 0; en1 = 1;
      q1.push_back({1'b0, 1'b1, 16'hF800});
      q1.push_back({1'b0, 1'b1, 16'h07E0});
      q1.push_back({1'b0, 1'b1, 16'h001F});
      q1.push_back({1'b1, 1'b1, 16'hFFFF});
      wait_rdy(1, "t3_rdy1");
      q0.push_back({1'b1, 1'b0, 16'h002C});
      en0 = 1;
      for (int i = 1; i <= 19; i++) begin
         @(negedge clk);
         chk($sformatf("t3_cs_c%0d", i), lcd_cs, (i <= 16) ? 0 : 1);
         chk($sformatf("t3_wr_c%0d", i), lcd_wr, (i <= 15 && (i % 4 == 2 || i % 4 == 3)) ? 0 : 1);
         chk($sformatf("t3_rdy0_c%0d", i), req0_ready, (i == 19) ? 1 : 0);
         chk($sformatf("t3_rdy1_c%0d", i), req1_ready, (i == 4 || i == 8 || i == 12) ? 1 : 0);
         case (i)
            2:  chk("t3_data0", data_output, 16'hF800);
            6:  chk("t3_data1", data_output, 16'h07E0);
            10: chk("t3_data2", data_output, 16'h001F);
            14: chk("t3_data3", data_output, 16'hFFFF);
            default: ;
         endcase
      end
      wait_idle("t3_idle");

      // req0 stalls mid-burst while req1 is waiting
      en1 = 0; en0 = 1;
      q0.push_back({1'b0, 1'b0, 16'h0050});
      wait_rdy(0, "t4_rdy0");
      q1.push_back({1'b1, 1'b1, 16'h1234});
      en1 = 1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         chk($sformatf("t4_cs_c%0d", i), lcd_cs, 0);
         chk($sformatf("t4_grant_c%0d", i), grant, 1);
         chk($sformatf("t4_rdy1_c%0d", i), req1_ready, 0);
         if (i >= 5) chk($sformatf("t4_wr_c%0d", i), lcd_wr, 1);
      end
      q0.push_back({1'b1, 1'b1, 16'h0051});
      @(negedge clk);
      chk("t4_resume_rdy0", req0_ready, 1);
      @(negedge clk);
      chk("t4_resume_data", data_output, 16'h0051);
      chk("t4_resume_rs", lcd_rs, 1);
      chk("t4_resume_grant", grant, 1);
      wait_idle("t4_idle");

      // reset during STROBE
      en0 = 0; en1 = 1;
      q1.push_back({1'b1, 1'b1, 16'hABCD});
      wait_rdy(1, "t5_rdy1");
      repeat (2) @(negedge clk);
      chk("t5_strobe_wr", lcd_wr, 0);
      rst = 1;
      @(negedge clk);
      chk("t5_rst_wr", lcd_wr, 1);
      chk("t5_rst_cs", lcd_cs, 1);
      chk("t5_rst_grant", grant, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_data", data_output, 0);
      rst = 0;
      q1.push_back({1'b1, 1'b1, 16'h5A5A});
      wait_rdy(1, "t5_new_rdy1");
      @(negedge clk);
      chk("t5_new_cs", lcd_cs, 0);
      chk("t5_new_data", data_output, 16'h5A5A);
      chk("t5_new_grant", grant, 2);
      @(negedge clk);
      @(negedge clk);
      chk("t5_new_wr", lcd_wr, 0);
      wait_idle("t5_idle");

      // non-default timing instance
      b_req0_valid = 1; b_req0_rs = 1; b_req0_data = 16'h00C3; b_req0_last = 1;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = b_req0_ready;
      end
      chk("t6_rdy0", {31'b0, seen}, 1);
      @(posedge clk);
      #1;
      b_req0_valid = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk($sformatf("t6_cs_c%0d", i), b_lcd_cs, (i <= 6) ? 0 : 1);
         chk($sformatf("t6_wr_c%0d", i), b_lcd_wr, (i >= 3 && i <= 5) ? 0 : 1);
         chk($sformatf("t6_busy_c%0d", i), b_busy, (i <= 7) ? 1 : 0);
         if (i == 1) chk("t6_data", b_data_output, 16'h00C3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hx8352_bus_arbiter.md
Name: hx8352_bus_arbiter

Overview:
- Shares the single HX8352 16-bit parallel write bus between two requesters: req0 (init/config sequencer) and req1 (pixel/fill engine).
- Each requester hands over command/data beats via valid/ready. The block arbitrates round-robin at burst boundaries and generates CS/RS/WR/RD timing from parameterised cycle counts.
- Sits between the LCD sequencers and the hx8352 pins in the top-level system.

Parameters:
- T_SETUP, 1, cycles CS low with RS/data valid before WR falls (1..15; 0 treated as 1)
- T_WR_LOW, 2, cycles WR held low (1..15; 0 treated as 1)
- T_HOLD, 1, cycles WR high with data held after rising edge (1..15; 0 treated as 1)
- T_CS_GAP, 2, cycles CS high between bursts before next arbitration (1..15; 0 treated as 1)

Ports:
- clk  in  1  system clock (clk_hs domain)
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has a beat
- req0_rs  in  1  0=command/index, 1=data
- req0_data  in  16  beat word
- req0_last  in  1  beat ends req0's burst (releases bus)
- req0_ready  out  1  beat accepted this cycle
- req1_valid, req1_rs, req1_data, req1_last, req1_ready  same as req0 for requester 1
- lcd_cs  out  1  chip select, active low
- lcd_rs  out  1  register select
- lcd_wr  out  1  write strobe, active low
- lcd_rd  out  1  read strobe, tied inactive high
- data_output  out  16  LCD data bus
- grant  out  2  one-hot current owner; 00 when idle or in gap
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock (clk); synchronous active-high reset (rst). All state updates on the rising edge of clk.
- Reset values: lcd_cs=1, lcd_wr=1, lcd_rd=1, lcd_rs=1, data_output=0, grant=00, busy=0, req*_ready=0, state=IDLE, last_owner=1 (req0 wins the first tie).
- Reset mid-operation: outputs reach reset values at the next edge. Any latched beat is discarded without a WR pulse completing.
- Handshake:
  - reqN_ready is combinational; it is high only on the acceptance cycle.
  - A beat transfers when valid&&ready.
  - Requesters hold valid/rs/data/last stable until ready.
  - The arbiter latches rs/data/last/owner on acceptance.
- States: IDLE, SETUP, STROBE, HOLD, WAIT, GAP. A 4-bit phase counter counts down in each timed state.
- IDLE arbitration:
  - Only one valid: that requester is accepted.
  - Both valid: the requester != last_owner is accepted.
  - On acceptance: next state SETUP, grant set.
  - No valid: remain in IDLE.
- SETUP: lcd_cs=0, lcd_wr=1, lcd_rs/data_output = latched values. Lasts T_SETUP cycles, then STROBE.
- STROBE: lcd_wr=0, everything else unchanged. Lasts T_WR_LOW cycles, then HOLD.
- HOLD: lcd_wr=1, data held. Lasts T_HOLD cycles. On the final HOLD cycle:
  - latched last=1: go to GAP, last_owner=owner.
  - last=0 and owner valid=1: owner ready=1 (accept next beat), go to SETUP. CS stays low.
  - last=0 and owner valid=0: go to WAIT.
- WAIT: CS low, WR high, data held, grant held.
  - The other requester is never accepted.
  - When owner valid=1: accept the beat (ready=1) and go to SETUP.
- GAP: lcd_cs=1, lcd_wr=1, grant=00, data held. Lasts T_CS_GAP cycles, then IDLE.
- Latency (defaults): acceptance at cycle 0.
  - CS falls at cycle 1; WR low cycles 2-3; WR rises at cycle 4; next in-burst acceptance at cycle 4.
  - Beat period = T_SETUP+T_WR_LOW+T_HOLD = 4 cycles.
  - Burst end plus gap adds T_CS_GAP=2 cycles.
- Ready rules: ready is never asserted to the non-owner during a burst. Both ready signals are never high in the same cycle.
- A requester dropping valid without ready has no effect; valid may be dropped before acceptance.

Test Plan:
- Reset, then req0 single beat (rs=0, data=0x0022, last=1) with defaults:
  - req0_ready high on cycle 0.
  - CS low cycles 1-4, WR low cycles 2-3.
  - data_output=0x0022, lcd_rs=0.
  - CS high cycles 5-6; back in IDLE at cycle 7.
- req0 and req1 both valid from reset with single-beat bursts, held for 3 bursts each:
  - grant order 01,10,01,10,01,10.
  - req0 is served first.
- req1 burst of 4 data beats (0xF800, 0x07E0, 0x001F, 0xFFFF, last on the 4th) while req0 is valid throughout:
  - 4 back-to-back WR pulses 4 cycles apart with CS continuously low.
  - req0_ready stays 0 until after the gap.
- req0 burst with last=0 then valid dropped for 10 cycles while req1 is valid:
  - stays in WAIT, CS low, grant=01, req1_ready=0.
  - req0 reasserts → its beat is accepted.
- rst asserted during STROBE:
  - next edge gives lcd_wr=1, lcd_cs=1, grant=00, busy=0, data_output=0.
  - after release, a new req1 beat is served normally.
- Parameters T_SETUP=2, T_WR_LOW=3, T_HOLD=0, T_CS_GAP=1:
  - WR low exactly 3 cycles, starting 2 cycles after CS falls.
  - hold is 1 cycle (0 treated as 1); gap is 1 cycle.
